neuron_mac: RTL and testbench

- Sequential signed fixed-point multiply-accumulate neuron. Computes y = sat(bias + sum over i of x[i]*w[i]) one term per cycle over INPUTS elements.
- Parametrised successor to the fixed 6-bit mult/adder/counter primitives: generic width, fraction bits and input count, with signed arithmetic, saturation and a valid/ready handshake on both sides.
- Sits between the input/weight register file and the perceptron decision/update logic.

---
 rtl/neuron_mac.sv | 96 +++++++++
 tb/tb_neuron_mac.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: sequential signed fixed-point MAC neuron, y = sat(bias + sum x*w); NEURON_RELU_EN adds ReLU on y
module neuron_mac #(
  parameter int WIDTH  = 6,
  parameter int FRAC   = 3,
  parameter int INPUTS = 4
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INPUTS*WIDTH-1:0]   x_vec,
  input  logic [INPUTS*WIDTH-1:0]   w_vec,
  input  logic [WIDTH-1:0]          bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      sat
);
  localparam int IDXW = $clog2(INPUTS);
  localparam int PW   = 2*WIDTH-FRAC;
  localparam int ACCW = PW+$clog2(INPUTS+1)+1;
  localparam logic signed [ACCW-1:0] MAX_V = ACCW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACCW-1:0] MIN_V = -MAX_V - 1;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  state_t                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic [INPUTS*WIDTH-1:0]   x_q, x_d, w_q, w_d;
  logic [WIDTH-1:0]          y_q, y_d;
  logic                      sat_q, sat_d;
  logic signed [WIDTH-1:0]   xe, we;
  logic signed [2*WIDTH-1:0] full;
  logic signed [PW-1:0]      prod;
  logic signed [ACCW-1:0]    sum, clamp_v;
  logic                      clamp_hit;
  always_comb begin
    xe        = x_q[idx_q*WIDTH +: WIDTH];
    we        = w_q[idx_q*WIDTH +: WIDTH];
    full      = xe * we;
    prod      = full[2*WIDTH-1:FRAC];
    sum       = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
    clamp_hit = (sum > MAX_V) || (sum < MIN_V);
    clamp_v   = sum > MAX_V ? MAX_V : sum < MIN_V ? MIN_V : sum;
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    x_d       = x_q;
    w_d       = w_q;
    y_d       = y_q;
    sat_d     = sat_q;
    if (state_q == IDLE && in_valid) begin
      x_d     = x_vec;
      w_d     = w_vec;
      acc_d   = {{(ACCW-WIDTH){bias[WIDTH-1]}}, bias};
      idx_d   = '0;
      state_d = ACCUM;
    end else if (state_q == ACCUM) begin
      acc_d = sum;
      idx_d = idx_q + 1'b1;
      if (idx_q == IDXW'(INPUTS-1)) begin
`ifdef NEURON_RELU_EN
        y_d   = clamp_v[ACCW-1] ? '0 : clamp_v[WIDTH-1:0];
`else
        y_d   = clamp_v[WIDTH-1:0];
`endif
        sat_d   = clamp_hit;
        state_d = OUT;
      end
    end else if (state_q == OUT && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign y         = y_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and random checks of neuron_mac against an integer reference model
module tb_neuron_mac;
  localparam int W = 6;
  localparam int F = 3;
  localparam int N = 4;
  logic             clk = 1'b0;
  logic             reset_l = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N*W-1:0]   x_vec = '0;
  logic [N*W-1:0]   w_vec = '0;
  logic [W-1:0]     bias = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     y;
  logic             sat;
  int               n_cmp = 0;
  int               n_err = 0;
  neuron_mac #(.WIDTH(W), .FRAC(F), .INPUTS(N)) dut (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready),
    .x_vec(x_vec), .w_vec(w_vec), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input int xa[N], input int wa[N], input int b,
                                output logic [W-1:0] yv, output logic sv);
    int acc, p, q, c;
    acc = b;
    for (int i = 0; i < N; i++) begin
      p = xa[i] * wa[i];
      q = p / (1 << F);
      if (p < 0 && q * (1 << F) != p) q = q - 1;
      acc = acc + q;
    end
    sv = (acc > 31) || (acc < -32);
    c  = acc > 31 ? 31 : acc < -32 ? -32 : acc;
`ifdef NEURON_RELU_EN
    if (c < 0) c = 0;
`endif
    yv = c[W-1:0];
  endfunction
  task automatic drive(input int xa[N], input int wa[N], input int b);
    for (int i = 0; i < N; i++) begin
      x_vec[i*W +: W] = xa[i][W-1:0];
      w_vec[i*W +: W] = wa[i][W-1:0];
    end
    bias = b[W-1:0];
  endtask
  task automatic scramble();
    x_vec = N*W'($urandom);
    w_vec = N*W'($urandom);
    bias  = W'($urandom);
  endtask
  task automatic do_op(input int xa[N], input int wa[N], input int b, input int hold);
    logic [W-1:0] ey;
    logic         es;
    model(xa, wa, b, ey, es);
    @(negedge clk);
    drive(xa, wa, b);
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    for (int k = 1; k < N; k++) begin
      chk("out_valid_early", out_valid, 1'b0);
      chk("in_ready_busy", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("out_valid_lat", out_valid, 1'b1);
    chk("y", y, ey);
    chk("sat", sat, es);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_y", y, ey);
      chk("bp_sat", sat, es);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("in_ready_back", in_ready, 1'b1);
    chk("y_hold", y, ey);
    chk("sat_hold", sat, es);
  endtask
  initial begin
    int xa[N];
    int wa[N];
    int b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 6'h00);
    chk("rst_sat", sat, 1'b0);
    reset_l = 1'b1;
    xa = '{8, 8, 0, 0};   wa = '{8, 4, 5, -7};   do_op(xa, wa, 2, 0);
    chk("basic_y", y, 6'd14);
    xa = '{8, 8, 8, 8};   wa = '{8, 8, 8, 8};    do_op(xa, wa, 0, 0);
    chk("pos_sat_y", y, 6'd31);
    xa = '{8, 8, 8, 8};   wa = '{-8, -8, -8, -8}; do_op(xa, wa, -8, 0);
`ifdef NEURON_RELU_EN
    chk("neg_sat_y", y, 6'h00);
`else
    chk("neg_sat_y", y, 6'h20);
`endif
    chk("neg_sat_s", sat, 1'b1);
    xa = '{1, -1, 0, 0};  wa = '{1, 1, 0, 0};    do_op(xa, wa, 0, 0);
`ifndef NEURON_RELU_EN
    chk("round_y", y, 6'h3F);
`endif
    xa = '{-32, -32, 31, 5}; wa = '{-32, 31, -32, 3}; do_op(xa, wa, -32, 5);
    xa = '{3, -5, 7, 2};  wa = '{6, 4, -3, 9};   do_op(xa, wa, 1, 0);
    @(negedge clk);
    xa = '{8, 8, 8, 8};   wa = '{8, 8, 8, 8};
    drive(xa, wa, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_y", y, 6'h00);
    chk("mid_rst_sat", sat, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_out", out_valid, 1'b0);
    xa = '{8, 8, 0, 0};   wa = '{8, 4, 5, -7};   do_op(xa, wa, 2, 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        xa[i] = int'($urandom_range(63)) - 32;
        wa[i] = int'($urandom_range(63)) - 32;
      end
      b = int'($urandom_range(63)) - 32;
      do_op(xa, wa, b, int'($urandom_range(2)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
